// File: rtl/onewire_pkg.sv
// Shared constants for the 1-wire line conditioning and timing blocks.
package onewire_pkg;

    localparam int unsigned DEBOUNCE_DELAY_DEF = 50000;
    localparam int unsigned PULSE_W_DEF        = 24;
    localparam int unsigned SYNC_STAGES_DEF    = 2;
    localparam int unsigned CNT_W_DEF          = 16;

    localparam logic ONEWIRE_IDLE = 1'b1;

    // Bus timing thresholds in cycles at 100 MHz, for the transceiver/MAC layer.
    localparam int unsigned RESET_LOW_MIN_CYC = 48000;
    localparam int unsigned PRESENCE_MIN_CYC  = 6000;
    localparam int unsigned PRESENCE_MAX_CYC  = 24000;

endpackage

// File: rtl/onewire_line_filter_ch.sv
// One line: synchroniser, stable-time debouncer, edge strobes and low-pulse timer.
module onewire_line_filter_ch
    import onewire_pkg::*;
#(
    parameter int unsigned DEBOUNCE_DELAY = DEBOUNCE_DELAY_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int unsigned PULSE_W        = PULSE_W_DEF,
    parameter logic        IDLE_LEVEL     = ONEWIRE_IDLE
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               line_i,
    output logic               level_o,
    output logic               rise_o,
    output logic               fall_o,
    output logic [PULSE_W-1:0] low_len_o,
    output logic               low_valid_o
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("onewire_line_filter_ch: SYNC_STAGES must be at least 2");
    end
    if ((longint'(DEBOUNCE_DELAY) >> CNT_W) != 0) begin : g_bad_cnt
        $error("onewire_line_filter_ch: CNT_W too narrow for DEBOUNCE_DELAY");
    end

    localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(DEBOUNCE_DELAY);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_cand;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;
    logic [PULSE_W-1:0]     r_lcnt;
    logic [PULSE_W-1:0]     r_low_len;
    logic                   r_low_valid;

    logic w_s;
    logic w_change;

    assign w_s      = r_sync[SYNC_STAGES-1];
    // Level is about to take the candidate value on this edge.
    assign w_change = (w_s == r_cand) && (r_cnt == DELAY_C) && (r_cand != r_level);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync      <= {SYNC_STAGES{IDLE_LEVEL}};
            r_cand      <= IDLE_LEVEL;
            r_cnt       <= '0;
            r_level     <= IDLE_LEVEL;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
            r_lcnt      <= '0;
            r_low_len   <= '0;
            r_low_valid <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], line_i};
            r_rise      <= w_change &  r_cand;
            r_fall      <= w_change & ~r_cand;
            r_low_valid <= w_change &  r_cand;

            if (w_s != r_cand) begin
                r_cand <= w_s;
                r_cnt  <= '0;
            end else if (r_cnt == DELAY_C) begin
                r_level <= r_cand;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Counter starts at 1 on the falling edge so the result equals cycles spent low.
            if (w_change && !r_cand) begin
                r_lcnt <= PULSE_W'(1);
            end else if (w_change && r_cand) begin
                r_low_len <= r_lcnt;
            end else if (!r_level && (r_lcnt != '1)) begin
                r_lcnt <= r_lcnt + PULSE_W'(1);
            end
        end
    end

    assign level_o     = r_level;
    assign rise_o      = r_rise;
    assign fall_o      = r_fall;
    assign low_len_o   = r_low_len;
    assign low_valid_o = r_low_valid;

endmodule

// File: rtl/onewire_line_filter.sv
// Multi-channel 1-wire input conditioner; one independent filter per line.
module onewire_line_filter
    import onewire_pkg::*;
#(
    parameter int unsigned CHANNELS       = 1,
    parameter int unsigned DEBOUNCE_DELAY = DEBOUNCE_DELAY_DEF,
    parameter int unsigned CNT_W          = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
    parameter int unsigned PULSE_W        = PULSE_W_DEF,
    parameter logic        IDLE_LEVEL     = ONEWIRE_IDLE
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [CHANNELS-1:0]         line_i,
    output logic [CHANNELS-1:0]         level_o,
    output logic [CHANNELS-1:0]         rise_o,
    output logic [CHANNELS-1:0]         fall_o,
    output logic [CHANNELS*PULSE_W-1:0] low_len_o,
    output logic [CHANNELS-1:0]         low_valid_o
);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        onewire_line_filter_ch #(
            .DEBOUNCE_DELAY (DEBOUNCE_DELAY),
            .CNT_W          (CNT_W),
            .SYNC_STAGES    (SYNC_STAGES),
            .PULSE_W        (PULSE_W),
            .IDLE_LEVEL     (IDLE_LEVEL)
        ) u_ch (
            .clock       (clock),
            .reset       (reset),
            .line_i      (line_i[k]),
            .level_o     (level_o[k]),
            .rise_o      (rise_o[k]),
            .fall_o      (fall_o[k]),
            .low_len_o   (low_len_o[k*PULSE_W +: PULSE_W]),
            .low_valid_o (low_valid_o[k])
        );
    end

endmodule

// File: tb/tb_onewire_line_filter.sv
// Directed bench for onewire_line_filter with two channels and a short debounce delay.
module tb_onewire_line_filter;

    localparam int unsigned CH  = 2;
    localparam int unsigned PW  = 8;

    logic          clock;
    logic          reset;
    logic [CH-1:0] line_i;
    logic [CH-1:0] level_o;
    logic [CH-1:0] rise_o;
    logic [CH-1:0] fall_o;
    logic [CH*PW-1:0] low_len_o;
    logic [CH-1:0] low_valid_o;

    int n_checks;
    int n_pass;

    onewire_line_filter #(
        .CHANNELS       (CH),
        .DEBOUNCE_DELAY (4),
        .CNT_W          (16),
        .SYNC_STAGES    (2),
        .PULSE_W        (PW),
        .IDLE_LEVEL     (1'b1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .line_i      (line_i),
        .level_o     (level_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .low_len_o   (low_len_o),
        .low_valid_o (low_valid_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive line ch low now (edge 0), release after edge low_n; record what happens over window edges.
    task automatic run_pulse(input int ch, input int low_n, input int window,
                             output int fall_at, output int rise_at, output int valid_at,
                             output int lev_at, output int n_str, output int n_other,
                             output int len);
        int oc;
        oc       = 1 - ch;
        fall_at  = -1;
        rise_at  = -1;
        valid_at = -1;
        lev_at   = -1;
        n_str    = 0;
        n_other  = 0;
        len      = -1;
        line_i[ch] = 1'b0;
        for (int i = 1; i <= window; i++) begin
            step();
            if (fall_o[ch]) begin
                if (fall_at < 0) fall_at = i;
                n_str++;
            end
            if (rise_o[ch]) begin
                if (rise_at < 0) rise_at = i;
                n_str++;
            end
            if (low_valid_o[ch]) begin
                if (valid_at < 0) valid_at = i;
                len = int'(low_len_o[ch*PW +: PW]);
                n_str++;
            end
            if (!level_o[ch] && lev_at < 0) lev_at = i;
            if (rise_o[ch] && fall_o[ch]) n_other++;
            if (fall_o[oc] || rise_o[oc] || low_valid_o[oc] || !level_o[oc]) n_other++;
            if (i == low_n) line_i[ch] = 1'b1;
        end
    endtask

    initial begin
        int fa, ra, va, la, ns, no, ln;
        logic [2:0] acc;
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        line_i   = 2'b11;

        // 1: reset state and quiet after release
        step(); step(); step();
        check_eq("rst_level", level_o, 2'b11);
        check_eq("rst_len", low_len_o, 16'h0000);
        check_eq("rst_strobes", {rise_o, fall_o, low_valid_o}, 6'b0);
        reset = 1'b0;
        acc = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            acc |= {|rise_o, |fall_o, |low_valid_o};
        end
        check_eq("post_rst_quiet", acc, 3'b000);
        check_eq("post_rst_level", level_o, 2'b11);

        // 2: 20-cycle low on channel 0
        run_pulse(0, 20, 40, fa, ra, va, la, ns, no, ln);
        check_eq("t2_fall_at", fa, 8);
        check_eq("t2_level_at", la, 8);
        check_eq("t2_rise_at", ra, 28);
        check_eq("t2_valid_at", va, 28);
        check_eq("t2_strobe_cnt", ns, 3);
        check_eq("t2_len", ln, 20);
        check_eq("t2_other", no, 0);
        check_eq("t2_len_hold", low_len_o, 16'h0014);

        // 3: 5-cycle glitch is filtered, 6-cycle pulse passes
        run_pulse(0, 5, 30, fa, ra, va, la, ns, no, ln);
        check_eq("t3a_strobes", ns, 0);
        check_eq("t3a_level", la, -1);
        check_eq("t3a_len_hold", low_len_o[7:0], 8'd20);
        run_pulse(0, 6, 30, fa, ra, va, la, ns, no, ln);
        check_eq("t3b_fall_at", fa, 8);
        check_eq("t3b_rise_at", ra, 14);
        check_eq("t3b_valid_at", va, 14);
        check_eq("t3b_strobe_cnt", ns, 3);
        check_eq("t3b_len", ln, 6);

        // 4: long low on channel 1 saturates
        run_pulse(1, 300, 320, fa, ra, va, la, ns, no, ln);
        check_eq("t4_fall_at", fa, 8);
        check_eq("t4_rise_at", ra, 308);
        check_eq("t4_len", ln, 255);
        check_eq("t4_other", no, 0);
        check_eq("t4_len_pack", low_len_o, 16'hFF06);

        // 5: channel 0 toggles every 10 cycles, channel 1 stays idle
        for (int r = 0; r < 3; r++) begin
            run_pulse(0, 10, 20, fa, ra, va, la, ns, no, ln);
            check_eq("t5_fall_at", fa, 8);
            check_eq("t5_rise_at", ra, 18);
            check_eq("t5_len", ln, 10);
            check_eq("t5_other", no, 0);
        end

        // 6: reset while a low pulse is being measured
        line_i[0] = 1'b0;
        for (int i = 0; i < 14; i++) step();
        check_eq("t6_pre_level", level_o[0], 1'b0);
        reset = 1'b1;
        step();
        check_eq("t6_rst_level", level_o, 2'b11);
        check_eq("t6_rst_strobes", {rise_o, fall_o, low_valid_o}, 6'b0);
        check_eq("t6_rst_len", low_len_o, 16'h0000);
        reset = 1'b0;
        fa  = -1;
        acc = '0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (fall_o[0] && fa < 0) fa = i;
            acc |= {|rise_o, |low_valid_o, fall_o[1]};
        end
        check_eq("t6_fall_at", fa, 8);
        check_eq("t6_no_rise", acc, 3'b000);
        check_eq("t6_level", level_o, 2'b10);

        line_i[0] = 1'b1;
        for (int i = 0; i < 10; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got %0d/%0d passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
